// File: rtl/alu_seq.sv
// Multi-cycle add/subtract ALU: one CHUNK-bit slice per clock, with a registered ripple carry.
// Optional signed saturation of the result when ALU_SEQ_SAT_EN is defined.
module alu_seq #(
   parameter int W     = 16,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [1:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] z,
   output logic         sign,
   output logic         zero,
   output logic         carry,
   output logic         parity,
   output logic         overflow,
   output logic         carry_flag
);
   localparam int N  = W / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   x_q, x_d, y_q, y_d, acc_q, acc_d, z_q, z_d;
   logic [KW-1:0]  k_q, k_d;
   logic           sub_q, sub_d, c_q, c_d;
   logic           xs_q, xs_d, ys_q, ys_d;
   logic           sign_q, sign_d, zero_q, zero_d, carry_q, carry_d;
   logic           parity_q, parity_d, ovf_q, ovf_d, cf_q, cf_d;

   logic [CHUNK:0] slice_sum;
   logic [W-1:0]   acc_shift, x_shift, y_shift, z_fin, y_in_eff;
   logic           ovf_raw, carry_fin;

   // Operands shift right one slice per cycle; the result shifts in from the top.
   assign slice_sum = {1'b0, x_q[CHUNK-1:0]} + {1'b0, y_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};

   generate
      if (N == 1) begin : g_single
         assign acc_shift = slice_sum[CHUNK-1:0];
         assign x_shift   = x_q;
         assign y_shift   = y_q;
      end else begin : g_multi
         assign acc_shift = {slice_sum[CHUNK-1:0], acc_q[W-1:CHUNK]};
         assign x_shift   = {{CHUNK{1'b0}}, x_q[W-1:CHUNK]};
         assign y_shift   = {{CHUNK{1'b0}}, y_q[W-1:CHUNK]};
      end
   endgenerate

   // Only meaningful on the last slice cycle, when acc_shift holds the full raw result.
   assign ovf_raw   = (xs_q == ys_q) && (acc_shift[W-1] != xs_q);
   assign carry_fin = slice_sum[CHUNK] ^ sub_q;
   assign y_in_eff  = op[0] ? ~y : y;

`ifdef ALU_SEQ_SAT_EN
   assign z_fin = ovf_raw ? (xs_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : acc_shift;
`else
   assign z_fin = acc_shift;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         acc_q    <= '0;
         z_q      <= '0;
         k_q      <= '0;
         sub_q    <= 1'b0;
         c_q      <= 1'b0;
         xs_q     <= 1'b0;
         ys_q     <= 1'b0;
         sign_q   <= 1'b0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         parity_q <= 1'b0;
         ovf_q    <= 1'b0;
         cf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         acc_q    <= acc_d;
         z_q      <= z_d;
         k_q      <= k_d;
         sub_q    <= sub_d;
         c_q      <= c_d;
         xs_q     <= xs_d;
         ys_q     <= ys_d;
         sign_q   <= sign_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         parity_q <= parity_d;
         ovf_q    <= ovf_d;
         cf_q     <= cf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      acc_d     = acc_q;
      z_d       = z_q;
      k_d       = k_q;
      sub_d     = sub_q;
      c_d       = c_q;
      xs_d      = xs_q;
      ys_d      = ys_q;
      sign_d    = sign_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      parity_d  = parity_q;
      ovf_d     = ovf_q;
      cf_d      = cf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               x_d     = x;
               y_d     = y_in_eff;
               xs_d    = x[W-1];
               ys_d    = y_in_eff[W-1];
               sub_d   = op[0];
               // ADD 0, SUB 1, ADC C, SBB ~C
               c_d     = op[1] ? (cf_q ^ op[0]) : op[0];
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            x_d   = x_shift;
            y_d   = y_shift;
            acc_d = acc_shift;
            c_d   = slice_sum[CHUNK];
            k_d   = k_q + KW'(1);
            if (k_q == K_LAST) begin
               z_d      = z_fin;
               sign_d   = z_fin[W-1];
               zero_d   = ~|z_fin;
               parity_d = ~^z_fin;
               ovf_d    = ovf_raw;
               carry_d  = carry_fin;
               cf_d     = carry_fin;
               state_d  = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign z          = z_q;
   assign sign       = sign_q;
   assign zero       = zero_q;
   assign carry      = carry_q;
   assign parity     = parity_q;
   assign overflow   = ovf_q;
   assign carry_flag = cf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (W=16, CHUNK=4); define ALU_SEQ_SAT_EN to check saturation.
module tb_alu_seq;
   localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_ADC = 2'd2, OP_SBB = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] x = '0, y = '0;
   logic [1:0]  op = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] z;
   logic        sign, zero, carry, parity, overflow, carry_flag;

   int n_pass  = 0;
   int n_total = 0;

   alu_seq #(.W(16), .CHUNK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .z(z), .sign(sign), .zero(zero), .carry(carry), .parity(parity),
      .overflow(overflow), .carry_flag(carry_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present a request, let it be accepted, scramble inputs, count cycles to out_valid.
   task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
      @(negedge clk);
      in_valid = 1'b1; op = o; x = a; y = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0; op = ~o; x = ~a; y = ~b;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic finish_op;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs: got %b want 10", {in_ready, out_valid});
      else n_pass++;
      n_total++;
      if (z !== 16'h0000) $display("FAIL reset_z: got %h want 0000", z);
      else n_pass++;
      n_total++;
      if ({sign, zero, carry, parity, overflow, carry_flag} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000", {sign, zero, carry, parity, overflow, carry_flag});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add_overflow;
      int lat;
      logic [15:0] ez;
      logic [4:0]  ef;
`ifdef ALU_SEQ_SAT_EN
      ez = 16'h7FFF; ef = 5'b00001;
`else
      ez = 16'h8000; ef = 5'b10001;
`endif
      do_op(OP_ADD, 16'h7FFF, 16'h0001, lat);
      n_total++;
      if (lat !== 4) $display("FAIL add_ovf_latency: got %0d want 4", lat);
      else n_pass++;
      n_total++;
      if (z !== ez) $display("FAIL add_ovf_z: got %h want %h", z, ez);
      else n_pass++;
      n_total++;
      if ({sign, zero, carry, parity, overflow} !== ef)
         $display("FAIL add_ovf_flags: got %b want %b", {sign, zero, carry, parity, overflow}, ef);
      else n_pass++;
      finish_op();
   endtask

   task automatic test_carry_chain;
      int lat;
      do_op(OP_ADD, 16'hFFFF, 16'h0001, lat);
      n_total++;
      if (z !== 16'h0000) $display("FAIL add_wrap_z: got %h want 0000", z);
      else n_pass++;
      n_total++;
      if ({sign, zero, carry, parity, overflow, carry_flag} !== 6'b011101)
         $display("FAIL add_wrap_flags: got %b want 011101", {sign, zero, carry, parity, overflow, carry_flag});
      else n_pass++;
      finish_op();
      do_op(OP_ADC, 16'h0000, 16'h0000, lat);
      n_total++;
      if (z !== 16'h0001) $display("FAIL adc_z: got %h want 0001", z);
      else n_pass++;
      n_total++;
      if ({carry, carry_flag} !== 2'b00) $display("FAIL adc_carry: got %b want 00", {carry, carry_flag});
      else n_pass++;
      finish_op();
   endtask

   task automatic test_sub_borrow;
      int lat;
      do_op(OP_SUB, 16'h0000, 16'h0001, lat);
      n_total++;
      if (z !== 16'hFFFF) $display("FAIL sub_borrow_z: got %h want ffff", z);
      else n_pass++;
      n_total++;
      if ({sign, zero, carry, parity, overflow, carry_flag} !== 6'b101101)
         $display("FAIL sub_borrow_flags: got %b want 101101", {sign, zero, carry, parity, overflow, carry_flag});
      else n_pass++;
      finish_op();
      do_op(OP_SBB, 16'h0005, 16'h0002, lat);
      n_total++;
      if (z !== 16'h0002) $display("FAIL sbb_z: got %h want 0002", z);
      else n_pass++;
      n_total++;
      if ({sign, zero, carry, parity, overflow, carry_flag} !== 6'b000000)
         $display("FAIL sbb_flags: got %b want 000000", {sign, zero, carry, parity, overflow, carry_flag});
      else n_pass++;
      finish_op();
      do_op(OP_SUB, 16'h0005, 16'h0005, lat);
      n_total++;
      if (z !== 16'h0000) $display("FAIL sub_zero_z: got %h want 0000", z);
      else n_pass++;
      n_total++;
      if ({sign, zero, carry, parity, overflow} !== 5'b01010)
         $display("FAIL sub_zero_flags: got %b want 01010", {sign, zero, carry, parity, overflow});
      else n_pass++;
      finish_op();
   endtask

   task automatic test_backpressure;
      int lat;
      do_op(OP_ADD, 16'h1234, 16'h1111, lat);
      @(negedge clk);
      in_valid = 1'b1; op = OP_ADD; x = 16'h0003; y = 16'h0004;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_total++;
         if ({out_valid, in_ready} !== 2'b10)
            $display("FAIL bp_hs_%0d: got %b want 10", i, {out_valid, in_ready});
         else n_pass++;
         n_total++;
         if ({z, sign, zero, carry, parity, overflow} !== {16'h2345, 5'b00010})
            $display("FAIL bp_hold_%0d: got %h/%b want 2345/00010", i, z, {sign, zero, carry, parity, overflow});
         else n_pass++;
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_total++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL bp_after_hs: got %b want 01", {out_valid, in_ready});
      else n_pass++;
      @(posedge clk);
      #1;
      in_valid = 1'b0; x = 16'hFFFF; y = 16'hFFFF;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL bp_accept: got in_ready %b want 0", in_ready);
      else n_pass++;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      n_total++;
      if (lat !== 4 || z !== 16'h0007)
         $display("FAIL bp_second: got lat %0d z %h want lat 4 z 0007", lat, z);
      else n_pass++;
      finish_op();
   endtask

   task automatic test_reset_mid_run;
      int lat;
      do_op(OP_ADD, 16'hFFFF, 16'h0001, lat);
      finish_op();
      @(negedge clk);
      in_valid = 1'b1; op = OP_ADD; x = 16'h0001; y = 16'h0002;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({in_ready, out_valid} !== 2'b10) $display("FAIL rst_run_hs: got %b want 10", {in_ready, out_valid});
      else n_pass++;
      n_total++;
      if ({z, sign, zero, carry, parity, overflow, carry_flag} !== 22'h0)
         $display("FAIL rst_run_state: got %h/%b want 0000/000000", z, {sign, zero, carry, parity, overflow, carry_flag});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(OP_ADD, 16'h0003, 16'h0004, lat);
      n_total++;
      if (lat !== 4 || z !== 16'h0007)
         $display("FAIL rst_run_next: got lat %0d z %h want lat 4 z 0007", lat, z);
      else n_pass++;
      finish_op();
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_carry_chain();
      test_sub_borrow();
      test_backpressure();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
